// File: rtl/framing_pkg.sv
`default_nettype none
//==============================================================================
// Module : framing_pkg
// Brief  : Shared framing constants and state encoding for deframer and framer.
// Rev    : 1.0  initial release
//==============================================================================
package framing_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0]  SFD_BYTE0     = 8'hF3;
    localparam logic [7:0]  SFD_BYTE1     = 8'h98;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL = 16'h8408;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        SYNC_F3 = 3'd1,
        SYNC_98 = 3'd2,
        PHR     = 3'd3,
        PSDU    = 3'd4,
        FCS     = 3'd5
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/crc16_byte.sv
`default_nettype none
//==============================================================================
// Module : crc16_byte
// Brief  : Combinational reflected CRC-16 (0x8408) update for one byte, LSB first.
// Rev    : 1.0  initial release
//==============================================================================
module crc16_byte
    import framing_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_crc
);

    logic [15:0] w_acc;

    always_comb begin
        w_acc = i_crc ^ {8'h00, i_byte};
        for (int i = 0; i < 8; i++) begin
            if (w_acc[0]) w_acc = (w_acc >> 1) ^ CRC_POLY_REFL;
            else          w_acc = w_acc >> 1;
        end
    end

    assign o_crc = w_acc;

endmodule
`default_nettype wire

// File: rtl/deframe_crc.sv
`default_nettype none
//==============================================================================
// Module : deframe_crc
// Brief  : Preamble/SFD hunt, PHR-length deframing and CRC-16 FCS check.
// Rev    : 1.0  initial release
//==============================================================================
module deframe_crc
    import framing_pkg::*;
#(
    parameter int PREAMBLE_MIN = 16,
    parameter int SFD_REPEAT   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       crc_ok,
    output logic       len_err
);

    localparam int c_pre_w = $clog2(PREAMBLE_MIN + 1);
    localparam int c_sfd_w = $clog2(SFD_REPEAT + 1);
    localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(PREAMBLE_MIN);
    localparam logic [c_pre_w-1:0] c_pre_one = c_pre_w'(1);
    localparam logic [c_sfd_w-1:0] c_sfd_max = c_sfd_w'(SFD_REPEAT);
    localparam logic [c_sfd_w-1:0] c_sfd_one = c_sfd_w'(1);

    frame_state_t       r_state, w_state;
    logic [c_pre_w-1:0] r_pre_cnt, w_pre_cnt;
    logic [c_sfd_w-1:0] r_sfd_cnt, w_sfd_cnt, w_sfd_inc;
    logic [6:0]         r_remaining, w_remaining, w_len;
    logic [15:0]        r_crc, w_crc, w_crc_next;
    logic [7:0]         r_dout, w_dout;
    logic               r_dout_valid, w_dout_valid;
    logic               r_frame_start, w_frame_start;
    logic               r_frame_end, w_frame_end;
    logic               r_crc_ok, w_crc_ok;
    logic               r_len_err, w_len_err;

    crc16_byte u_crc (
        .i_crc  (r_crc),
        .i_byte (din),
        .o_crc  (w_crc_next)
    );

    assign w_len     = din[6:0];
    assign w_sfd_inc = r_sfd_cnt + c_sfd_one;

    always_comb begin
        w_state       = r_state;
        w_pre_cnt     = r_pre_cnt;
        w_sfd_cnt     = r_sfd_cnt;
        w_remaining   = r_remaining;
        w_crc         = r_crc;
        w_dout        = r_dout;
        w_dout_valid  = 1'b0;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_crc_ok      = 1'b0;
        w_len_err     = 1'b0;
        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (din == PREAMBLE_BYTE) begin
                        if (r_pre_cnt != c_pre_max) w_pre_cnt = r_pre_cnt + c_pre_one;
                    end else begin
                        w_pre_cnt = '0;
                        if (din == SFD_BYTE0 && r_pre_cnt == c_pre_max) begin
                            w_state   = SYNC_F3;
                            w_sfd_cnt = c_sfd_one;
                        end
                    end
                end
                // r_sfd_cnt counts F3 bytes seen; once full, the first 0x98 is expected
                SYNC_F3: begin
                    if (r_sfd_cnt != c_sfd_max && din == SFD_BYTE0) begin
                        w_sfd_cnt = w_sfd_inc;
                    end else if (r_sfd_cnt == c_sfd_max && din == SFD_BYTE1) begin
                        w_state   = (SFD_REPEAT == 1) ? PHR : SYNC_98;
                        w_sfd_cnt = (SFD_REPEAT == 1) ? '0 : c_sfd_one;
                    end else begin
                        w_state   = HUNT;
                        w_sfd_cnt = '0;
                        w_pre_cnt = (din == PREAMBLE_BYTE) ? c_pre_one : '0;
                    end
                end
                SYNC_98: begin
                    if (din == SFD_BYTE1) begin
                        w_sfd_cnt = (w_sfd_inc == c_sfd_max) ? '0 : w_sfd_inc;
                        w_state   = (w_sfd_inc == c_sfd_max) ? PHR : SYNC_98;
                    end else begin
                        w_state   = HUNT;
                        w_sfd_cnt = '0;
                        w_pre_cnt = (din == PREAMBLE_BYTE) ? c_pre_one : '0;
                    end
                end
                PHR: begin
                    if (w_len < 7'd2) begin
                        w_len_err = 1'b1;
                        w_state   = HUNT;
                    end else begin
                        w_dout        = din;
                        w_dout_valid  = 1'b1;
                        w_frame_start = 1'b1;
                        w_crc         = w_crc_next;
                        w_remaining   = w_len;
                        w_state       = (w_len == 7'd2) ? FCS : PSDU;
                    end
                end
                PSDU: begin
                    w_dout       = din;
                    w_dout_valid = 1'b1;
                    w_crc        = w_crc_next;
                    w_remaining  = r_remaining - 7'd1;
                    if (r_remaining == 7'd3) w_state = FCS;
                end
                FCS: begin
                    w_crc       = w_crc_next;
                    w_remaining = r_remaining - 7'd1;
                    if (r_remaining == 7'd1) begin
                        w_frame_end = 1'b1;
                        w_crc_ok    = (w_crc_next == 16'h0000);
                        w_crc       = CRC_INIT;
                        w_state     = HUNT;
                    end
                end
                default: begin
                    w_state = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= HUNT;
            r_pre_cnt     <= '0;
            r_sfd_cnt     <= '0;
            r_remaining   <= '0;
            r_crc         <= CRC_INIT;
            r_dout        <= 8'h00;
            r_dout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_crc_ok      <= 1'b0;
            r_len_err     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_pre_cnt     <= w_pre_cnt;
            r_sfd_cnt     <= w_sfd_cnt;
            r_remaining   <= w_remaining;
            r_crc         <= w_crc;
            r_dout        <= w_dout;
            r_dout_valid  <= w_dout_valid;
            r_frame_start <= w_frame_start;
            r_frame_end   <= w_frame_end;
            r_crc_ok      <= w_crc_ok;
            r_len_err     <= w_len_err;
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign crc_ok      = r_crc_ok;
    assign len_err     = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_deframe_crc.sv
`default_nettype none
//==============================================================================
// Module : tb_deframe_crc
// Brief  : Self-checking bench for deframe_crc with a byte-level frame model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_deframe_crc;

    localparam int         PMIN = 16;
    localparam int         SREP = 8;
    localparam logic [7:0] AA   = 8'hAA;
    localparam logic [7:0] F3   = 8'hF3;
    localparam logic [7:0] N98  = 8'h98;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic [7:0] dout;
    logic       dout_valid, frame_start, frame_end, crc_ok, len_err;

    int n_checks = 0;
    int n_errors = 0;
    int gap      = 0;

    always #5 clk = ~clk;

    deframe_crc #(.PREAMBLE_MIN(PMIN), .SFD_REPEAT(SREP)) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .crc_ok      (crc_ok),
        .len_err     (len_err)
    );

    // Bit-serial CRC: each message bit is compared with the register LSB
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 16'h8408;
            else                       r = r >> 1;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model state
    int          m_pre, m_sync, m_left;
    logic [15:0] m_crc;
    logic [7:0]  e_dout;
    bit          e_dv, e_fs, e_fe, e_ok, e_le;
    int          obs_dv, obs_fs, obs_fe, obs_ok, obs_le;
    logic [7:0]  obs_fs_dout;

    task automatic model_reset();
        m_pre = 0; m_sync = 0; m_left = 0; m_crc = 16'hFFFF;
        e_dout = 8'h00; e_dv = 0; e_fs = 0; e_fe = 0; e_ok = 0; e_le = 0;
    endtask

    task automatic model_step(input logic [7:0] b);
        logic [7:0] want;
        e_dv = 0; e_fs = 0; e_fe = 0; e_ok = 0; e_le = 0;
        if (m_left > 0) begin
            m_crc = crc_upd(m_crc, b);
            if (m_left > 2) begin e_dv = 1; e_dout = b; end
            m_left--;
            if (m_left == 0) begin e_fe = 1; e_ok = (m_crc == 16'h0000); m_crc = 16'hFFFF; end
        end else if (m_sync == 2 * SREP) begin
            m_sync = 0;
            if (int'(b[6:0]) < 2) e_le = 1;
            else begin
                e_dv = 1; e_fs = 1; e_dout = b;
                m_crc = crc_upd(16'hFFFF, b);
                m_left = int'(b[6:0]);
            end
        end else if (m_sync > 0) begin
            want = (m_sync < SREP) ? F3 : N98;
            if (b == want) m_sync++;
            else begin m_sync = 0; m_pre = (b == AA) ? 1 : 0; end
        end else begin
            if (b == AA) m_pre = (m_pre < PMIN) ? m_pre + 1 : PMIN;
            else if (b == F3 && m_pre >= PMIN) begin m_sync = 1; m_pre = 0; end
            else m_pre = 0;
        end
    endtask

    initial model_reset();

    always begin
        @(posedge clk);
        if (reset) model_reset();
        else if (din_valid) model_step(din);
        else begin e_dv = 0; e_fs = 0; e_fe = 0; e_ok = 0; e_le = 0; end
        #1;
        check("dout", dout, e_dout);
        check("dout_valid", dout_valid, e_dv);
        check("frame_start", frame_start, e_fs);
        check("frame_end", frame_end, e_fe);
        check("len_err", len_err, e_le);
        if (e_fe) check("crc_ok", crc_ok, e_ok);
        if (dout_valid === 1'b1) obs_dv++;
        if (frame_start === 1'b1) begin obs_fs++; obs_fs_dout = dout; end
        if (frame_end === 1'b1) begin obs_fe++; if (crc_ok === 1'b1) obs_ok++; end
        if (len_err === 1'b1) obs_le++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk); din = b; din_valid = 1'b1;
        repeat (gap) begin @(negedge clk); din_valid = 1'b0; din = 8'($urandom); end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); din_valid = 1'b0; end
    endtask

    task automatic send_pre_sfd(input int npre);
        repeat (npre) send(AA);
        repeat (SREP) send(F3);
        repeat (SREP) send(N98);
    endtask

    task automatic send_frame(input logic [7:0] phr, input int npay, input logic [7:0] fill, input bit corrupt);
        logic [15:0] c;
        c = crc_upd(16'hFFFF, phr);
        send(phr);
        for (int i = 0; i < npay; i++) begin c = crc_upd(c, fill); send(fill); end
        send(c[7:0]);
        send(c[15:8] ^ {7'd0, corrupt});
    endtask

    int s_dv, s_fs, s_fe, s_ok, s_le;
    task automatic snap();
        s_dv = obs_dv; s_fs = obs_fs; s_fe = obs_fe; s_ok = obs_ok; s_le = obs_le;
    endtask

    task automatic expect_counts(input string tag, input int dv, input int fs, input int fe, input int ok, input int le);
        check({tag, "_dv_count"}, obs_dv - s_dv, dv);
        check({tag, "_fs_count"}, obs_fs - s_fs, fs);
        check({tag, "_fe_count"}, obs_fe - s_fe, fe);
        check({tag, "_ok_count"}, obs_ok - s_ok, ok);
        check({tag, "_le_count"}, obs_le - s_le, le);
    endtask

    initial begin
        reset = 1'b1; din = 8'h00; din_valid = 1'b0;
        #1;
        check("rst_dout", dout, 8'h00);
        check("rst_flags", {dout_valid, frame_start, frame_end, crc_ok, len_err}, 5'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("model_crc_phr02", crc_upd(16'hFFFF, 8'h02), 16'h2C95);
        check("model_residue_good", crc_upd(crc_upd(16'h2C95, 8'h95), 8'h2C), 16'h0000);

        // Scenario 1: literal good frame
        snap();
        repeat (64) send(AA);
        repeat (SREP) send(F3);
        repeat (SREP) send(N98);
        send(8'h02); send(8'h95); send(8'h2C); idle(3);
        expect_counts("s1", 1, 1, 1, 1, 0);
        check("s1_phr_dout", obs_fs_dout, 8'h02);

        // Scenario 2: corrupted last FCS byte
        snap();
        send_pre_sfd(64); send(8'h02); send(8'h95); send(8'h2D); idle(3);
        expect_counts("s2", 1, 1, 1, 0, 0);

        // Scenario 3: preamble one byte short, then exact minimum
        snap();
        send_pre_sfd(15); send(8'h02); send(8'h95); send(8'h2C); idle(3);
        expect_counts("s3a", 0, 0, 0, 0, 0);
        snap();
        send_pre_sfd(16); send(8'h02); send(8'h95); send(8'h2C); idle(3);
        expect_counts("s3b", 1, 1, 1, 1, 0);

        // Scenario 4: SFD broken by 0xAA which counts as first preamble byte; short PHR
        snap();
        repeat (16) send(AA);
        repeat (7) send(F3);
        send(AA);
        send_pre_sfd(15); send(8'h01); idle(3);
        expect_counts("s4", 0, 0, 0, 0, 1);

        // Scenario 5: stalls between every byte
        snap();
        gap = 3;
        send_pre_sfd(64); send(8'h02); send(8'h95); send(8'h2C);
        gap = 0;
        idle(4);
        expect_counts("s5", 1, 1, 1, 1, 0);
        check("s5_phr_dout", obs_fs_dout, 8'h02);

        // Preamble-looking payload, then L=2 frame with PHR bit 7 set
        snap();
        send_pre_sfd(16); send_frame(8'h14, 18, AA, 1'b0); idle(2);
        expect_counts("s7a", 19, 1, 1, 1, 0);
        snap();
        send_pre_sfd(16); send_frame(8'h82, 0, 8'h00, 1'b0); idle(2);
        expect_counts("s7b", 1, 1, 1, 1, 0);
        check("s7b_phr_dout", obs_fs_dout, 8'h82);

        // Scenario 6: reset mid-frame
        snap();
        send_pre_sfd(16); send(8'h05); send(8'h11);
        @(negedge clk); reset = 1'b1; din_valid = 1'b0;
        #1;
        check("s6_rst_dout", dout, 8'h00);
        check("s6_rst_flags", {dout_valid, frame_start, frame_end, crc_ok, len_err}, 5'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(4);
        check("s6_no_frame_end", obs_fe - s_fe, 0);
        snap();
        send_pre_sfd(16); send_frame(8'h06, 4, 8'h3C, 1'b0); idle(3);
        expect_counts("s6b", 5, 1, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/deframe_crc.md
DEFRAME_CRC -- requirements
Module: deframe_crc

Interface
REQ-001 Parameter PREAMBLE_MIN, default 16: minimum consecutive 0xAA bytes before SFD search is armed.
REQ-002 Parameter SFD_REPEAT, default 8: number of 0xF3 bytes and then 0x98 bytes required in the SFD.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  8  received byte stream.
REQ-006 din_valid  input  1  din is consumed this cycle when high; low stalls without state change.
REQ-007 dout  output  8  recovered PHR/PSDU byte, FCS excluded.
REQ-008 dout_valid  output  1  dout qualifier.
REQ-009 frame_start  output  1  one-cycle pulse coincident with the PHR byte on dout.
REQ-010 frame_end  output  1  one-cycle pulse after the last FCS byte.
REQ-011 crc_ok  output  1  valid only with frame_end; high means FCS check passed.
REQ-012 len_err  output  1  one-cycle pulse when PHR length < 2.

Function
REQ-013 States are HUNT, SYNC_F3, SYNC_98, PHR, PSDU and FCS; all transitions occur only on din_valid cycles.
REQ-014 HUNT counts consecutive 0xAA bytes, saturating at PREAMBLE_MIN; any other byte clears the count; after the count reaches PREAMBLE_MIN, 0xF3 moves to SYNC_F3 with sfd_cnt=1.
REQ-015 SYNC_F3 requires SFD_REPEAT total 0xF3 bytes, then SYNC_98 requires SFD_REPEAT 0x98 bytes; any mismatch returns to HUNT with preamble count 1 if the byte is 0xAA, else 0.
REQ-016 PHR byte: L=din[6:0], din[7] ignored; if L<2, pulse len_err and return to HUNT with no output; else output PHR, pulse frame_start, load remaining=L.
REQ-017 PSDU outputs the next L-2 bytes; FCS consumes 2 bytes (low byte first) that are not output; with L=2, PSDU is skipped.
REQ-018 CRC is 16-bit, init 0xFFFF, reflected polynomial 0x8408 (x^16+x^12+x^5+1), LSB-first, one full byte per valid cycle.
REQ-019 CRC covers the PHR, PSDU and both FCS bytes; crc_ok=1 if and only if the residue is 0x0000 after the second FCS byte.
REQ-020 After the second FCS byte, the block pulses frame_end with crc_ok for one cycle and returns to HUNT with the CRC reset to 0xFFFF.
REQ-021 Latency: dout, dout_valid and frame_start are registered, one cycle after the accepting din_valid edge; frame_end is one cycle after the last FCS byte is accepted.
REQ-022 No timeout: din_valid low holds all state indefinitely; outputs pulse low during the stall.
REQ-023 A new preamble arriving mid-frame is treated as data; resync occurs only after the frame ends.
REQ-024 dout holds its last value when dout_valid is low; pulse outputs are never high for more than one cycle.

Reset
REQ-025 Reset asserted at any time forces state=HUNT, all counters=0, CRC=0xFFFF, and dout=0x00 with every output flag low, within the same cycle.
REQ-026 A frame interrupted by reset produces no frame_end; the block resumes preamble hunt after reset deasserts.

Structure
REQ-027 The shared package framing_pkg holds PREAMBLE_BYTE=0xAA, SFD_BYTE0=0xF3, SFD_BYTE1=0x98, CRC_INIT=0xFFFF, CRC_POLY_REFL=0x8408 and the state enum, which the encoder-side block also uses.
REQ-028 A combinational sub-module crc16_byte (inputs crc[15:0] and byte[7:0], output next crc) implements 8 unrolled bit steps and is reusable by the framer.

Verification
REQ-029 Scenario 1: 64x0xAA, 8x0xF3, 8x0x98, 0x02, 0x95, 0x2C -> frame_start with dout=0x02, then frame_end with crc_ok=1, and no other dout_valid.
REQ-030 Scenario 2: the same frame with the last byte 0x2D -> frame_end with crc_ok=0.
REQ-031 Scenario 3: 15x0xAA then the SFD -> no sync; 16x0xAA then the SFD -> frame detected.
REQ-032 Scenario 4: 7x0xF3 then 0xAA -> returns to HUNT with preamble count 1; PHR=0x01 after a valid SFD -> len_err pulse and no frame_start.
REQ-033 Scenario 5: scenario 1 with din_valid low for 3 cycles between every byte -> identical output sequence.
REQ-034 Scenario 6: reset asserted after the PHR of a frame -> outputs 0 immediately, no frame_end, and a following clean frame decodes with crc_ok=1.
